// File: rtl/frame_serializer_if.sv
// Frame-in / byte-out handshake bundle for frame_serializer.
// slave: serializer side; master: coprocessor plus UART TX side.
interface frame_serializer_if #(
    parameter int WIDTH = 144
);
    logic [WIDTH-1:0] frame_in;
    logic             frame_valid;
    logic             busy;
    logic             dropped;
    logic             done;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport slave (
        input  frame_in,
        input  frame_valid,
        input  tx_ready,
        output busy,
        output dropped,
        output done,
        output tx_data,
        output tx_valid
    );

    modport master (
        output frame_in,
        output frame_valid,
        output tx_ready,
        input  busy,
        input  dropped,
        input  done,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/frame_serializer.sv
// Single-frame buffer that streams a wide result frame out byte by byte.
// Define FRAME_SER_CRLF_EN to append CR, LF after the last payload byte.
module frame_serializer #(
    parameter int NUM_BYTES = 18,
    parameter int WIDTH     = NUM_BYTES * 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    frame_serializer_if.slave bus
);
    localparam int IW = $clog2(NUM_BYTES) + 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CR,
        LF
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] frame_q;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic             busy_q;
    logic             dropped_q;
    logic             done_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;

    // Byte i in transmit order, independent of frame endianness.
    function automatic logic [7:0] pick(
        input logic [WIDTH-1:0] f,
        input logic [IW-1:0]    i
    );
        int k;
        logic [WIDTH-1:0] s;
        k = MSB_FIRST ? (NUM_BYTES - 1 - int'(i)) : int'(i);
        s = f >> (8 * k);
        return s[7:0];
    endfunction

    assign idx_nxt = idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_q    <= '0;
            idx        <= '0;
            busy_q     <= 1'b0;
            dropped_q  <= 1'b0;
            done_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            dropped_q <= bus.frame_valid && busy_q;
            done_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        frame_q    <= bus.frame_in;
                        idx        <= '0;
                        state      <= SEND;
                        busy_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= pick(bus.frame_in, '0);
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (idx == LAST) begin
`ifdef FRAME_SER_CRLF_EN
                            state     <= CR;
                            tx_data_q <= 8'h0D;
`else
                            state      <= IDLE;
                            idx        <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
`endif
                        end else begin
                            idx       <= idx_nxt;
                            tx_data_q <= pick(frame_q, idx_nxt);
                        end
                    end
                end
                CR: begin
                    if (bus.tx_ready) begin
                        state     <= LF;
                        tx_data_q <= 8'h0A;
                    end
                end
                LF: begin
                    if (bus.tx_ready) begin
                        state      <= IDLE;
                        idx        <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.dropped  = dropped_q;
    assign bus.done     = done_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
endmodule
